// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and helpers for the write-through data cache.
//   state_t        - controller states (IDLE, REFILL, WRITE, RESUME)
//   calc_*_w       - address field widths derived from WIDTH/SETS/LINE_WORDS
//   byte_merge     - overlay the enabled bytes of data onto word
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    RESUME = 2'd3
  } state_t;

  function automatic int calc_offset_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int calc_index_w(input int sets);
    return $clog2(sets);
  endfunction

  // Tag is whatever remains above index, word offset and the 2 byte bits.
  function automatic int calc_tag_w(input int width, input int sets, input int line_words);
    return width - $clog2(sets) - $clog2(line_words) - 2;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] word,
                                             input logic [31:0] data,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    merged = word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        merged[8*b +: 8] = data[8*b +: 8];
      end else begin
        merged[8*b +: 8] = word[8*b +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag, valid and data storage of the direct-mapped cache.
//   rd_index/rd_offset/rd_tag -> rd_hit, rd_data : combinational lookup
//   wr_en/wr_index/wr_offset/wr_data/wr_be       : one word write, byte enables
//   tv_we/tv_index/tv_tag/tv_valid               : tag + valid write
//   rst clears every valid bit; tag and data contents are not reset.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [calc_index_w(SETS)-1:0]              rd_index,
  input  logic [calc_offset_w(LINE_WORDS)-1:0]       rd_offset,
  input  logic [calc_tag_w(WIDTH,SETS,LINE_WORDS)-1:0] rd_tag,
  output logic                                       rd_hit,
  output logic [WIDTH-1:0]                           rd_data,
  input  logic                                       wr_en,
  input  logic [calc_index_w(SETS)-1:0]              wr_index,
  input  logic [calc_offset_w(LINE_WORDS)-1:0]       wr_offset,
  input  logic [WIDTH-1:0]                           wr_data,
  input  logic [3:0]                                 wr_be,
  input  logic                                       tv_we,
  input  logic [calc_index_w(SETS)-1:0]              tv_index,
  input  logic [calc_tag_w(WIDTH,SETS,LINE_WORDS)-1:0] tv_tag,
  input  logic                                       tv_valid
);

  localparam int OFFSET_W = calc_offset_w(LINE_WORDS);
  localparam int INDEX_W  = calc_index_w(SETS);
  localparam int TAG_W    = calc_tag_w(WIDTH, SETS, LINE_WORDS);

  logic [WIDTH-1:0] data_r  [SETS*LINE_WORDS];
  logic [TAG_W-1:0] tag_r   [SETS];
  logic [SETS-1:0]  valid_r;

  assign rd_data = data_r[{rd_index, rd_offset}];
  assign rd_hit  = valid_r[rd_index] && (tag_r[rd_index] == rd_tag);

  // Data word write with byte merge (full-word refills use wr_be = 4'hF).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_r[{wr_index, wr_offset}] <= byte_merge(data_r[{wr_index, wr_offset}], wr_data, wr_be);
    end
  end

  // Tag write; contents are meaningless while the matching valid bit is clear.
  always_ff @(posedge clk) begin
    if (tv_we) begin
      tag_r[tv_index] <= tv_tag;
    end
  end

  // Valid bits: reset wins over any same-edge set, so an interrupted line stays invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= {SETS{1'b0}};
    end else if (tv_we) begin
      valid_r[tv_index] <= tv_valid;
    end
  end

endmodule

// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, no-write-allocate MEM-stage data cache.
//   mem_read_m/mem_write_m/addr_m/write_data_m/byte_en_m : MEM-stage access
//   read_data_m  : combinational array word for addr_m
//   cache_stall  : freeze the pipeline
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be, mem_ready/mem_rdata : memory beats
//   hit_count/miss_count : wrapping load hit/miss counters
module dcache_wt
  import dcache_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read_m,
  input  logic             mem_write_m,
  input  logic [WIDTH-1:0] addr_m,
  input  logic [WIDTH-1:0] write_data_m,
  input  logic [3:0]       byte_en_m,
  output logic [WIDTH-1:0] read_data_m,
  output logic             cache_stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
);

  localparam int OFFSET_W = calc_offset_w(LINE_WORDS);
  localparam int INDEX_W  = calc_index_w(SETS);
  localparam int TAG_W    = calc_tag_w(WIDTH, SETS, LINE_WORDS);
  localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(LINE_WORDS - 1);
  localparam logic [OFFSET_W-1:0] BEAT_ONE  = OFFSET_W'(1);

  state_t              state_r, state_s;
  logic [OFFSET_W-1:0] beat_r, beat_s;
  logic [31:0]         hit_count_r, miss_count_r;
  logic                hit_inc_s, miss_inc_s;

  logic [OFFSET_W-1:0] off_s;
  logic [INDEX_W-1:0]  idx_s;
  logic [TAG_W-1:0]    tag_s;
  logic                hit_s;

  logic                wr_en_s, tv_we_s, tv_valid_s;
  logic [OFFSET_W-1:0] wr_off_s;
  logic [WIDTH-1:0]    wr_data_s;
  logic [3:0]          wr_be_s;

  assign off_s = addr_m[2 +: OFFSET_W];
  assign idx_s = addr_m[2 + OFFSET_W +: INDEX_W];
  assign tag_s = addr_m[WIDTH-1 -: TAG_W];

  assign hit_count  = hit_count_r;
  assign miss_count = miss_count_r;

  dcache_array #(.WIDTH(WIDTH), .SETS(SETS), .LINE_WORDS(LINE_WORDS)) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (idx_s),
    .rd_offset (off_s),
    .rd_tag    (tag_s),
    .rd_hit    (hit_s),
    .rd_data   (read_data_m),
    .wr_en     (wr_en_s),
    .wr_index  (idx_s),
    .wr_offset (wr_off_s),
    .wr_data   (wr_data_s),
    .wr_be     (wr_be_s),
    .tv_we     (tv_we_s),
    .tv_index  (idx_s),
    .tv_tag    (tag_s),
    .tv_valid  (tv_valid_s)
  );

  // Next-state, memory interface and array write control.
  always_comb begin
    state_s     = state_r;
    beat_s      = beat_r;
    cache_stall = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = {WIDTH{1'b0}};
    mem_wdata   = {WIDTH{1'b0}};
    mem_be      = 4'b0000;
    wr_en_s     = 1'b0;
    wr_off_s    = off_s;
    wr_data_s   = write_data_m;
    wr_be_s     = byte_en_m;
    tv_we_s     = 1'b0;
    tv_valid_s  = 1'b0;
    hit_inc_s   = 1'b0;
    miss_inc_s  = 1'b0;
    case (state_r)
      IDLE: begin
        // A simultaneous read+write is handled as a store.
        if (mem_write_m) begin
          cache_stall = 1'b1;
          state_s     = WRITE;
        end else if (mem_read_m) begin
          if (hit_s) begin
            hit_inc_s = 1'b1;
          end else begin
            cache_stall = 1'b1;
            miss_inc_s  = 1'b1;
            beat_s      = {OFFSET_W{1'b0}};
            tv_we_s     = 1'b1;     // invalidate now so a partial line never hits
            tv_valid_s  = 1'b0;
            state_s     = REFILL;
          end
        end else begin
          state_s = IDLE;
        end
      end
      REFILL: begin
        cache_stall = 1'b1;
        mem_req     = 1'b1;
        mem_addr    = {tag_s, idx_s, beat_r, 2'b00};
        if (mem_ready) begin
          wr_en_s   = 1'b1;
          wr_off_s  = beat_r;
          wr_data_s = mem_rdata;
          wr_be_s   = 4'b1111;
          beat_s    = beat_r + BEAT_ONE;
          if (beat_r == LAST_BEAT) begin
            tv_we_s    = 1'b1;
            tv_valid_s = 1'b1;
            state_s    = RESUME;
          end else begin
            state_s = REFILL;
          end
        end else begin
          state_s = REFILL;
        end
      end
      WRITE: begin
        cache_stall = 1'b1;
        mem_req     = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = {addr_m[WIDTH-1:2], 2'b00};
        mem_wdata   = write_data_m;
        mem_be      = byte_en_m;
        if (mem_ready) begin
          wr_en_s = hit_s;          // no-write-allocate: a miss leaves the cache alone
          state_s = RESUME;
        end else begin
          state_s = WRITE;
        end
      end
      RESUME: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, beat counter and statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      beat_r       <= {OFFSET_W{1'b0}};
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
    end else begin
      state_r <= state_s;
      beat_r  <= beat_s;
      if (hit_inc_s) begin
        hit_count_r <= hit_count_r + 32'd1;
      end
      if (miss_inc_s) begin
        miss_count_r <= miss_count_r + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_dcache_wt.sv
// tb_dcache_wt: randomized self-checking bench for dcache_wt. The reference
// model tracks which line address is resident per set and a sparse backing
// memory; since the cache is write-through, a load must return memory content.
module tb_dcache_wt;

  localparam int SETS = 64;
  localparam int LW   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_m, mem_write_m;
  logic [31:0] addr_m, write_data_m;
  logic [3:0]  byte_en_m;
  logic [31:0] read_data_m;
  logic        cache_stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  dcache_wt dut (
    .clk(clk), .rst(rst), .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
    .addr_m(addr_m), .write_data_m(write_data_m), .byte_en_m(byte_en_m),
    .read_data_m(read_data_m), .cache_stall(cache_stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .hit_count(hit_count),
    .miss_count(miss_count)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem_words [int unsigned];
  int          resident [SETS];
  logic [31:0] exp_hits, exp_misses;

  logic [31:0] q_addr[$];
  logic        q_we[$];
  logic [31:0] q_wdata[$];
  logic [3:0]  q_be[$];
  logic        q_rdy[$];
  logic        final_req;

  function automatic logic [31:0] mem_rd(input logic [31:0] word_idx);
    if (mem_words.exists(word_idx)) return mem_words[word_idx];
    return 32'hA000_0000 + word_idx;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) resident[s] = -1;
    exp_hits   = 32'd0;
    exp_misses = 32'd0;
  endtask

  // kind: 0 idle, 1 load, 2 store, 3 load+store (acts as store)
  task automatic model_access(input int kind, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              output bit miss, output logic [31:0] exp_data);
    logic [31:0] line;
    logic [31:0] word;
    int set;
    line = addr / 32'd16;
    set  = int'(line % SETS);
    miss = 1'b0;
    exp_data = mem_rd(addr / 32'd4);
    if (kind == 1) begin
      if (resident[set] == int'(line)) begin
        exp_hits = exp_hits + 32'd1;
      end else begin
        miss = 1'b1;
        exp_misses = exp_misses + 32'd1;
        resident[set] = int'(line);
      end
    end else if (kind >= 2) begin
      word = mem_rd(addr / 32'd4);
      for (int b = 0; b < 4; b++)
        if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
      mem_words[addr / 32'd4] = word;
    end
  endtask

  // rmode: 0 ready always high, 1 random ready, 2 ready low 3 cycles on beat 2
  task automatic run_access(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input int rmode,
                            output int stall_cyc, output logic [31:0] rdata);
    int beats, lowcnt;
    logic r;
    q_addr.delete(); q_we.delete(); q_wdata.delete(); q_be.delete(); q_rdy.delete();
    @(negedge clk);
    mem_read_m   = (kind == 1 || kind == 3);
    mem_write_m  = (kind >= 2);
    addr_m       = addr;
    write_data_m = wdata;
    byte_en_m    = be;
    #1;
    stall_cyc = 0; beats = 0; lowcnt = 0;
    while (cache_stall && stall_cyc < 100) begin
      case (rmode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = !(beats == 2 && lowcnt < 3);
      endcase
      if (mem_req) begin
        q_addr.push_back(mem_addr); q_we.push_back(mem_we);
        q_wdata.push_back(mem_wdata); q_be.push_back(mem_be); q_rdy.push_back(r);
        if (r) beats++; else lowcnt++;
      end
      mem_ready = r;
      mem_rdata = mem_rd(mem_addr / 32'd4);
      @(posedge clk); #1;
      stall_cyc++;
    end
    mem_ready = 1'b0;
    rdata     = read_data_m;
    final_req = mem_req;
    @(posedge clk); #1;
    mem_read_m  = 1'b0;
    mem_write_m = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_read_m = 1'b0; mem_write_m = 1'b0; addr_m = 32'd0;
    write_data_m = 32'd0; byte_en_m = 4'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (cache_stall !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: stall=%b req=%b we=%b, required 0 0 0", cache_stall, mem_req, mem_we);
    end
    vectors++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_counters: hit=%0d miss=%0d, required 0 0", hit_count, miss_count);
    end
    @(negedge clk); rst = 1'b0;
    model_reset();
  endtask

  task automatic test_first_refill();
    bit miss; logic [31:0] exp, rd; int sc;
    model_access(1, 32'h100, 32'd0, 4'd0, miss, exp);
    run_access(1, 32'h100, 32'd0, 4'd0, 0, sc, rd);
    vectors++;
    if (sc !== LW + 1) begin miscompares++; $display("FAIL refill_stall: got %0d cycles, required %0d", sc, LW + 1); end
    vectors++;
    if (q_addr.size() != LW) begin
      miscompares++; $display("FAIL refill_beats: got %0d req cycles, required %0d", q_addr.size(), LW);
    end else begin
      for (int i = 0; i < LW; i++) begin
        vectors++;
        if (q_addr[i] !== 32'h100 + 32'(4*i) || q_we[i] !== 1'b0) begin
          miscompares++; $display("FAIL refill_addr%0d: got %h we=%b, required %h we=0", i, q_addr[i], q_we[i], 32'h100 + 32'(4*i));
        end
      end
    end
    vectors++;
    if (rd !== exp) begin miscompares++; $display("FAIL refill_data: got %h, required %h", rd, exp); end
    vectors++;
    if (miss_count !== exp_misses || hit_count !== exp_hits) begin
      miscompares++; $display("FAIL refill_counts: hit=%0d miss=%0d, required %0d %0d", hit_count, miss_count, exp_hits, exp_misses);
    end
  endtask

  task automatic test_hit();
    bit miss; logic [31:0] exp, rd; int sc;
    model_access(1, 32'h108, 32'd0, 4'd0, miss, exp);
    run_access(1, 32'h108, 32'd0, 4'd0, 0, sc, rd);
    vectors++;
    if (sc !== 0 || final_req !== 1'b0 || q_addr.size() != 0) begin
      miscompares++; $display("FAIL hit_nostall: stall=%0d req=%b beats=%0d, required 0 0 0", sc, final_req, q_addr.size());
    end
    vectors++;
    if (rd !== exp) begin miscompares++; $display("FAIL hit_data: got %h, required %h", rd, exp); end
    vectors++;
    if (hit_count !== exp_hits) begin miscompares++; $display("FAIL hit_count: got %0d, required %0d", hit_count, exp_hits); end
  endtask

  task automatic test_store_hit();
    bit miss; logic [31:0] exp, rd; int sc;
    model_access(2, 32'h104, 32'h1234_5678, 4'b0011, miss, exp);
    run_access(2, 32'h104, 32'h1234_5678, 4'b0011, 0, sc, rd);
    vectors++;
    if (sc !== 2 || q_addr.size() != 1) begin
      miscompares++; $display("FAIL store_stall: stall=%0d beats=%0d, required 2 1", sc, q_addr.size());
    end else begin
      vectors++;
      if (q_we[0] !== 1'b1 || q_be[0] !== 4'b0011 || q_addr[0] !== 32'h104 || q_wdata[0] !== 32'h1234_5678) begin
        miscompares++; $display("FAIL store_beat: we=%b be=%b addr=%h data=%h, required 1 0011 104 12345678", q_we[0], q_be[0], q_addr[0], q_wdata[0]);
      end
    end
    model_access(1, 32'h104, 32'd0, 4'd0, miss, exp);
    run_access(1, 32'h104, 32'd0, 4'd0, 0, sc, rd);
    vectors++;
    if (sc !== 0 || rd !== exp) begin
      miscompares++; $display("FAIL store_merge: stall=%0d data=%h, required 0 %h", sc, rd, exp);
    end
  endtask

  task automatic test_store_miss();
    bit miss; logic [31:0] exp, rd; int sc;
    model_access(2, 32'h2000, 32'hDEAD_BEEF, 4'b1111, miss, exp);
    run_access(2, 32'h2000, 32'hDEAD_BEEF, 4'b1111, 0, sc, rd);
    vectors++;
    if (sc !== 2 || q_addr.size() != 1) begin
      miscompares++; $display("FAIL store_miss_beat: stall=%0d beats=%0d, required 2 1", sc, q_addr.size());
    end
    model_access(1, 32'h2000, 32'd0, 4'd0, miss, exp);
    run_access(1, 32'h2000, 32'd0, 4'd0, 0, sc, rd);
    vectors++;
    if (sc !== LW + 1 || rd !== exp || miss_count !== exp_misses) begin
      miscompares++; $display("FAIL store_no_alloc: stall=%0d data=%h miss=%0d, required %0d %h %0d", sc, rd, miss_count, LW + 1, exp, exp_misses);
    end
  endtask

  task automatic test_ready_stall();
    bit miss; logic [31:0] exp, rd; int sc, beats;
    model_access(1, 32'h400, 32'd0, 4'd0, miss, exp);
    run_access(1, 32'h400, 32'd0, 4'd0, 2, sc, rd);
    vectors++;
    if (sc !== LW + 1 + 3 || q_addr.size() != LW + 3) begin
      miscompares++; $display("FAIL ready_wait_stall: stall=%0d reqs=%0d, required %0d %0d", sc, q_addr.size(), LW + 4, LW + 3);
    end
    beats = 0;
    foreach (q_addr[i]) begin
      vectors++;
      if (q_addr[i] !== 32'h400 + 32'(4*beats)) begin
        miscompares++; $display("FAIL ready_wait_addr%0d: got %h, required %h", i, q_addr[i], 32'h400 + 32'(4*beats));
      end
      if (q_rdy[i]) beats++;
    end
    vectors++;
    if (rd !== exp) begin miscompares++; $display("FAIL ready_wait_data: got %h, required %h", rd, exp); end
  endtask

  task automatic test_reset_mid_refill();
    bit miss; logic [31:0] exp, rd; int sc;
    @(negedge clk);
    mem_read_m = 1'b1; mem_write_m = 1'b0; addr_m = 32'h300; mem_ready = 1'b1;
    @(posedge clk); #1;                         // now refilling beat 0
    mem_rdata = mem_rd(mem_addr / 32'd4);
    @(posedge clk); #1;                         // now refilling beat 1
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h304) begin
      miscompares++; $display("FAIL midrefill_beat1: req=%b addr=%h, required 1 304", mem_req, mem_addr);
    end
    rst = 1'b1; mem_read_m = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (mem_req !== 1'b0 || cache_stall !== 1'b0 || hit_count !== 32'd0 || miss_count !== 32'd0) begin
      miscompares++; $display("FAIL midrefill_reset: req=%b stall=%b hit=%0d miss=%0d, required 0 0 0 0", mem_req, cache_stall, hit_count, miss_count);
    end
    rst = 1'b0;
    model_reset();
    model_access(1, 32'h300, 32'd0, 4'd0, miss, exp);
    run_access(1, 32'h300, 32'd0, 4'd0, 0, sc, rd);
    vectors++;
    if (sc !== LW + 1 || rd !== exp || miss_count !== exp_misses) begin
      miscompares++; $display("FAIL midrefill_again: stall=%0d data=%h miss=%0d, required %0d %h %0d", sc, rd, miss_count, LW + 1, exp, exp_misses);
    end
  endtask

  task automatic test_random();
    bit miss; logic [31:0] exp, rd, addr, wdata; logic [3:0] be;
    int sc, kind, sel, waits, beats, base_cyc;
    for (int n = 0; n < 80; n++) begin
      sel  = int'($urandom_range(0, 7));
      kind = (sel == 0) ? 0 : (sel <= 4) ? 1 : (sel <= 6) ? 2 : 3;
      addr = 32'($urandom_range(0, 3)) * 32'd1024 + 32'($urandom_range(0, 3)) * 32'd16
           + 32'($urandom_range(0, 3)) * 32'd4 + 32'($urandom_range(0, 3));
      wdata = $urandom;
      be    = 4'($urandom_range(0, 15));
      model_access(kind, addr, wdata, be, miss, exp);
      run_access(kind, addr, wdata, be, 1, sc, rd);
      waits = 0;
      foreach (q_rdy[i]) if (!q_rdy[i]) waits++;
      base_cyc = (kind >= 2) ? 2 : (kind == 1 && miss) ? LW + 1 : 0;
      vectors++;
      if (sc !== base_cyc + waits) begin
        miscompares++; $display("FAIL rand%0d_stall: kind=%0d addr=%h got %0d, required %0d", n, kind, addr, sc, base_cyc + waits);
      end
      if (kind == 1) begin
        vectors++;
        if (rd !== exp) begin miscompares++; $display("FAIL rand%0d_data: addr=%h got %h, required %h", n, addr, rd, exp); end
        beats = 0;
        foreach (q_addr[i]) begin
          vectors++;
          if (q_we[i] !== 1'b0 || q_addr[i] !== (addr & 32'hFFFF_FFF0) + 32'(4*beats)) begin
            miscompares++; $display("FAIL rand%0d_refill_addr: got %h we=%b, required %h we=0", n, q_addr[i], q_we[i], (addr & 32'hFFFF_FFF0) + 32'(4*beats));
          end
          if (q_rdy[i]) beats++;
        end
      end else if (kind >= 2) begin
        foreach (q_addr[i]) begin
          vectors++;
          if (q_we[i] !== 1'b1 || q_addr[i] !== (addr & 32'hFFFF_FFFC) || q_wdata[i] !== wdata || q_be[i] !== be) begin
            miscompares++; $display("FAIL rand%0d_store_beat: we=%b addr=%h data=%h be=%b, required 1 %h %h %b", n, q_we[i], q_addr[i], q_wdata[i], q_be[i], addr & 32'hFFFF_FFFC, wdata, be);
          end
        end
      end
      vectors++;
      if (hit_count !== exp_hits || miss_count !== exp_misses) begin
        miscompares++; $display("FAIL rand%0d_counts: hit=%0d miss=%0d, required %0d %0d", n, hit_count, miss_count, exp_hits, exp_misses);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_first_refill();
    test_hit();
    test_store_hit();
    test_store_miss();
    test_ready_stall();
    test_reset_mid_refill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
